// File: rtl/pmu_domain_sequencer_pkg.sv
// Shared types and helpers for the power-domain sequencer: FSM state encoding,
// domain index constants and the priority pickers used by the SCAN step.
package pmu_seq_pkg;

  localparam int N_DOM_DEF   = 5;
  localparam int DOM_MAX     = 8;  // err_dom_o is 3 bits wide, so at most 8 domains

  localparam int DOM_LOGIC   = 0;
  localparam int DOM_L2      = 1;
  localparam int DOM_L2_UDMA = 2;
  localparam int DOM_L1      = 3;
  localparam int DOM_UDMA    = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DN_CLK,
    ST_DN_ISO,
    ST_DN_RST,
    ST_DN_SLEEP,
    ST_DN_WAIT,
    ST_UP_WAKE,
    ST_UP_WAIT,
    ST_UP_SETTLE,
    ST_UP_ISO,
    ST_UP_CLK,
    ST_ERR,
    ST_DONE
  } seq_state_e;

  function automatic logic [2:0] pick_highest(input logic [DOM_MAX-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < DOM_MAX; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [2:0] pick_lowest(input logic [DOM_MAX-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = DOM_MAX - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pmu_domain_sequencer_timer.sv
// Saturating cycle counter with clear/enable and a terminal-count compare.
// One instance serves both the ack timeout and the post-wake settle delay.
module pmu_seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_tc,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  // Clear wins over enable; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt >= i_tc);

endmodule

// File: rtl/pmu_domain_sequencer.sv
// Power-domain sequencer: walks one domain at a time through clock-gate, isolate,
// reset and switch-off (or the reverse) until the committed on-mask matches the target.
module pmu_domain_sequencer
  import pmu_seq_pkg::*;
#(
  parameter int N_DOM       = N_DOM_DEF,
  parameter int ACK_TIMEOUT = 255,
  parameter int SETTLE_CYC  = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [N_DOM-1:0] req_mask_i,
  output logic [N_DOM-1:0] sleep_send_o,
  input  logic [N_DOM-1:0] sleep_ack_i,
  output logic [N_DOM-1:0] iso_en_o,
  output logic [N_DOM-1:0] dom_rstn_o,
  output logic [N_DOM-1:0] clk_en_o,
  output logic [N_DOM-1:0] on_mask_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [2:0]       err_dom_o
);

  localparam logic [CNT_W-1:0] ACK_TC    = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE_CYC - 1);

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;

  logic [N_DOM-1:0] r_target,   w_target_nxt;
  logic [N_DOM-1:0] r_on_mask,  w_on_nxt;
  logic [N_DOM-1:0] r_sleep,    w_sleep_nxt;
  logic [N_DOM-1:0] r_iso,      w_iso_nxt;
  logic [N_DOM-1:0] r_rstn,     w_rstn_nxt;
  logic [N_DOM-1:0] r_clk_en,   w_clk_nxt;
  logic [2:0]       r_dom,      w_dom_nxt;
  logic             r_err,      w_err_nxt;
  logic [2:0]       r_err_dom,  w_err_dom_nxt;

  logic [N_DOM-1:0] w_off_set;
  logic [N_DOM-1:0] w_on_set;
  logic [N_DOM-1:0] w_dom_oh;
  logic             w_ack;
  logic             w_tmr_clr;
  logic             w_tmr_en;
  logic [CNT_W-1:0] w_tmr_tc;
  logic             w_tmr_done;

  assign w_off_set = r_on_mask & ~r_target;
  assign w_on_set  = ~r_on_mask & r_target;
  assign w_dom_oh  = N_DOM'(1) << r_dom;
  assign w_ack     = |(sleep_ack_i & w_dom_oh);
  assign w_tmr_tc  = (r_state == ST_UP_SETTLE) ? SETTLE_TC : ACK_TC;

  pmu_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .i_clr  (w_tmr_clr),
    .i_en   (w_tmr_en),
    .i_tc   (w_tmr_tc),
    .o_tc   (w_tmr_done)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (req_valid_i) w_state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (w_off_set != '0)     w_state_nxt = ST_DN_CLK;
        else if (w_on_set != '0) w_state_nxt = ST_UP_WAKE;
        else                     w_state_nxt = ST_DONE;
      end
      ST_DN_CLK:    w_state_nxt = ST_DN_ISO;
      ST_DN_ISO:    w_state_nxt = ST_DN_RST;
      ST_DN_RST:    w_state_nxt = ST_DN_SLEEP;
      ST_DN_SLEEP:  w_state_nxt = ST_DN_WAIT;
      ST_DN_WAIT: begin
        if (w_ack)           w_state_nxt = ST_SCAN;
        else if (w_tmr_done) w_state_nxt = ST_ERR;
      end
      ST_UP_WAKE:   w_state_nxt = ST_UP_WAIT;
      ST_UP_WAIT: begin
        if (!w_ack)          w_state_nxt = ST_UP_SETTLE;
        else if (w_tmr_done) w_state_nxt = ST_ERR;
      end
      ST_UP_SETTLE: if (w_tmr_done) w_state_nxt = ST_UP_ISO;
      ST_UP_ISO:    w_state_nxt = ST_UP_CLK;
      ST_UP_CLK:    w_state_nxt = ST_SCAN;
      ST_ERR:       w_state_nxt = ST_IDLE;
      ST_DONE:      w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // Each state touches only the bits of r_dom, so a single domain moves per cycle.
  always_comb begin
    w_target_nxt  = r_target;
    w_on_nxt      = r_on_mask;
    w_sleep_nxt   = r_sleep;
    w_iso_nxt     = r_iso;
    w_rstn_nxt    = r_rstn;
    w_clk_nxt     = r_clk_en;
    w_dom_nxt     = r_dom;
    w_err_nxt     = r_err;
    w_err_dom_nxt = r_err_dom;
    w_tmr_clr     = 1'b0;
    w_tmr_en      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid_i) begin
          w_target_nxt = req_mask_i;
          w_err_nxt    = 1'b0;
        end
      end
      ST_SCAN: begin
        if (w_off_set != '0)     w_dom_nxt = pick_highest(DOM_MAX'(w_off_set));
        else if (w_on_set != '0) w_dom_nxt = pick_lowest(DOM_MAX'(w_on_set));
      end
      ST_DN_CLK:   w_clk_nxt  = r_clk_en & ~w_dom_oh;
      ST_DN_ISO:   w_iso_nxt  = r_iso | w_dom_oh;
      ST_DN_RST:   w_rstn_nxt = r_rstn & ~w_dom_oh;
      ST_DN_SLEEP: begin
        w_sleep_nxt = r_sleep | w_dom_oh;
        w_tmr_clr   = 1'b1;
      end
      ST_DN_WAIT: begin
        if (w_ack) w_on_nxt = r_on_mask & ~w_dom_oh;
        else       w_tmr_en = 1'b1;
      end
      ST_UP_WAKE: begin
        w_sleep_nxt = r_sleep & ~w_dom_oh;
        w_tmr_clr   = 1'b1;
      end
      ST_UP_WAIT: begin
        if (!w_ack) w_tmr_clr = 1'b1;
        else        w_tmr_en  = 1'b1;
      end
      ST_UP_SETTLE: begin
        w_tmr_en = 1'b1;
        if (w_tmr_done) w_rstn_nxt = r_rstn | w_dom_oh;
      end
      ST_UP_ISO:   w_iso_nxt = r_iso & ~w_dom_oh;
      ST_UP_CLK: begin
        w_clk_nxt = r_clk_en | w_dom_oh;
        w_on_nxt  = r_on_mask | w_dom_oh;
      end
      ST_ERR: begin
        w_err_nxt     = 1'b1;
        w_err_dom_nxt = r_dom;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_target  <= '1;
      r_on_mask <= '1;
      r_sleep   <= '0;
      r_iso     <= '0;
      r_rstn    <= '1;
      r_clk_en  <= '1;
      r_dom     <= '0;
      r_err     <= 1'b0;
      r_err_dom <= '0;
    end else begin
      r_target  <= w_target_nxt;
      r_on_mask <= w_on_nxt;
      r_sleep   <= w_sleep_nxt;
      r_iso     <= w_iso_nxt;
      r_rstn    <= w_rstn_nxt;
      r_clk_en  <= w_clk_nxt;
      r_dom     <= w_dom_nxt;
      r_err     <= w_err_nxt;
      r_err_dom <= w_err_dom_nxt;
    end
  end

  // Handshake: a request transfers on a rising edge where req_valid_i & req_ready_o;
  // ready is high only in IDLE and a valid seen while busy is dropped, not queued.
  assign req_ready_o  = (r_state == ST_IDLE);
  assign busy_o       = ~req_ready_o;
  assign done_o       = (r_state == ST_DONE);
  assign err_o        = r_err;
  assign err_dom_o    = r_err_dom;
  assign sleep_send_o = r_sleep;
  assign iso_en_o     = r_iso;
  assign dom_rstn_o   = r_rstn;
  assign clk_en_o     = r_clk_en;
  assign on_mask_o    = r_on_mask;

  logic [N_DOM-1:0] w_chg;
  assign w_chg = (w_sleep_nxt ^ r_sleep) | (w_iso_nxt ^ r_iso) | (w_rstn_nxt ^ r_rstn)
               | (w_clk_nxt ^ r_clk_en) | (w_on_nxt ^ r_on_mask);

  a_iso_covers_off: assert property (@(posedge clk_i) disable iff (!rstn_i)
    ~|((r_sleep | ~r_rstn) & ~r_iso));
  a_clk_off_when_iso: assert property (@(posedge clk_i) disable iff (!rstn_i)
    ~|(r_iso & r_clk_en));
  a_one_domain_moves: assert property (@(posedge clk_i) disable iff (!rstn_i)
    $onehot0(w_chg));

endmodule

// File: tb/tb_pmu_domain_sequencer.sv
// Directed bench for pmu_domain_sequencer: a switch model answers sleep_send with a
// programmable ack delay, and a monitor scores every done/err event against exp_q.
module tb_pmu_domain_sequencer;

  localparam int N_DOM      = 5;
  localparam int SETTLE_CYC = 4;
  localparam int SW         = 30;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             req_valid = 1'b0;
  logic [N_DOM-1:0] req_mask = '0;
  logic [N_DOM-1:0] sleep_ack = '0;
  logic             req_ready_o;
  logic [N_DOM-1:0] sleep_send_o;
  logic [N_DOM-1:0] iso_en_o;
  logic [N_DOM-1:0] dom_rstn_o;
  logic [N_DOM-1:0] clk_en_o;
  logic [N_DOM-1:0] on_mask_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic [2:0]       err_dom_o;

  pmu_domain_sequencer dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_mask_i   (req_mask),
    .sleep_send_o (sleep_send_o),
    .sleep_ack_i  (sleep_ack),
    .iso_en_o     (iso_en_o),
    .dom_rstn_o   (dom_rstn_o),
    .clk_en_o     (clk_en_o),
    .on_mask_o    (on_mask_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .err_dom_o    (err_dom_o)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [SW-1:0] exp_q[$];
  string         name_q[$];
  int            n_vec = 0;
  int            n_miss = 0;
  int            acc_cyc = 0;
  int            out_cyc = 0;
  logic          err_prev = 1'b0;

  function automatic logic [SW-1:0] mk_snap(input logic dn, input logic er, input logic [2:0] ed,
                                            input logic [4:0] sl, input logic [4:0] iso,
                                            input logic [4:0] rs, input logic [4:0] ce,
                                            input logic [4:0] on);
    return {dn, er, ed, sl, iso, rs, ce, on};
  endfunction

  function automatic logic [SW-1:0] dut_snap();
    return mk_snap(done_o, err_o, err_dom_o, sleep_send_o, iso_en_o, dom_rstn_o, clk_en_o, on_mask_o);
  endfunction

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string name, input logic [SW-1:0] snap);
    exp_q.push_back(snap);
    name_q.push_back(name);
  endtask

  // ---------------- switch model ----------------
  int ack_dly = 0;
  bit ack_stuck = 1'b0;
  int acnt[N_DOM];

  // Ack follows sleep_send and becomes visible ack_dly cycles after the change.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < N_DOM; d++) begin
        if (sleep_send_o[d] !== sleep_ack[d]) begin
          if (!(ack_stuck && sleep_send_o[d])) begin
            acnt[d]++;
            if (acnt[d] > ack_dly) begin
              sleep_ack[d] = sleep_send_o[d];
              acnt[d] = 0;
            end
          end
        end else begin
          acnt[d] = 0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [SW-1:0] exp_v;
    string         nm;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        err_prev = 1'b0;
      end else begin
        if (done_o || (err_o && !err_prev)) begin
          out_cyc = cyc;
          if (exp_q.size() == 0) begin
            check("unexpected_output", dut_snap(), '0);
            if (dut_snap() == '0) begin
              n_miss++;
              $display("FAIL unexpected_output: got done/err event, expected none");
            end
          end else begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            check(nm, dut_snap(), exp_v);
          end
        end
        err_prev = err_o;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [N_DOM-1:0] m);
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready_o && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check("ready_timeout", SW'(req_ready_o), SW'(1));
    req_valid = 1'b1;
    req_mask  = m;
    acc_cyc   = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int bound);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check({name, "_timeout"}, SW'(exp_q.size()), SW'(0));
      exp_q.delete();
      name_q.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  localparam logic [SW-1:0] RST_SNAP = {1'b0, 1'b0, 3'd0, 5'b00000, 5'b00000, 5'b11111, 5'b11111, 5'b11111};

  initial begin
    int t;
    int c0;

    // 1: reset with valid held high
    rstn      = 1'b0;
    req_valid = 1'b1;
    req_mask  = 5'b00000;
    repeat (3) @(negedge clk);
    check("t1_reset_outputs", dut_snap(), RST_SNAP);
    rstn      = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check("t1_ready_after_release", SW'({req_ready_o, busy_o}), SW'(2'b10));
    check("t1_outputs_after_release", dut_snap(), RST_SNAP);

    // 2: no-change request
    push_exp("t2_done", mk_snap(1'b1, 1'b0, 3'd0, 5'b00000, 5'b00000, 5'b11111, 5'b11111, 5'b11111));
    send_req(5'b11111);
    drain("t2", 20);
    check("t2_latency", SW'(out_cyc - acc_cyc), SW'(2));

    // 3: power down domains 4 and 0, ack 3 cycles after sleep_send
    ack_dly = 3;
    push_exp("t3_done", mk_snap(1'b1, 1'b0, 3'd0, 5'b10001, 5'b10001, 5'b01110, 5'b01110, 5'b01110));
    send_req(5'b01110);
    t = 0;
    while (clk_en_o == 5'b11111 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t3_first_down_is_dom4", SW'(clk_en_o), SW'(5'b01111));
    drain("t3", 100);
    check("t3_latency", SW'(out_cyc - acc_cyc), SW'(20));

    // 4: power both back up, ack falls 2 cycles after release
    ack_dly = 2;
    push_exp("t4_done", RST_SNAP | {1'b1, 29'd0});
    send_req(5'b11111);
    t = 0;
    while (sleep_send_o == 5'b10001 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t4_first_up_is_dom0", SW'(sleep_send_o), SW'(5'b10000));
    t = 0;
    while (sleep_ack[0] !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    c0 = cyc;
    t = 0;
    while (dom_rstn_o[0] !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    // The ack is taken on the edge after it is seen; reset releases SETTLE_CYC edges later.
    check("t4_settle_delay", SW'(cyc - c0), SW'(SETTLE_CYC + 1));
    drain("t4", 100);
    check("t4_latency", SW'(out_cyc - acc_cyc), SW'(24));

    // 5: domain 1 never acks -> timeout
    ack_dly   = 0;
    ack_stuck = 1'b1;
    push_exp("t5_err", mk_snap(1'b0, 1'b1, 3'd1, 5'b00010, 5'b00010, 5'b11101, 5'b11101, 5'b11111));
    send_req(5'b11101);
    drain("t5", 400);
    check("t5_latency", SW'(out_cyc - acc_cyc), SW'(262));
    push_exp("t5_err_clear", mk_snap(1'b1, 1'b0, 3'd1, 5'b00010, 5'b00010, 5'b11101, 5'b11101, 5'b11111));
    send_req(5'b11111);
    drain("t5b", 20);
    check("t5b_latency", SW'(out_cyc - acc_cyc), SW'(2));

    // 6: reset mid-settle, request pulsed while busy
    @(negedge clk);
    rstn      = 1'b0;
    ack_stuck = 1'b0;
    ack_dly   = 0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    name_q.delete();
    check("t6_reset_outputs", dut_snap(), RST_SNAP);
    rstn = 1'b1;
    push_exp("t6_down_dom4", mk_snap(1'b1, 1'b0, 3'd0, 5'b10000, 5'b10000, 5'b01111, 5'b01111, 5'b01111));
    send_req(5'b01111);
    drain("t6a", 50);
    check("t6_single_down_latency", SW'(out_cyc - acc_cyc), SW'(8));
    ack_dly = 2;
    send_req(5'b11111);
    check("t6_busy_not_ready", SW'({req_ready_o, busy_o}), SW'(2'b01));
    req_valid = 1'b1;
    req_mask  = 5'b00000;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (sleep_ack[4] !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check("t6_in_settle_rstn_low", SW'(dom_rstn_o), SW'(5'b01111));
    rstn = 1'b0;
    @(negedge clk);
    check("t6_reset_mid_settle", dut_snap(), RST_SNAP);
    check("t6_ready_in_reset", SW'({req_ready_o, busy_o}), SW'(2'b10));
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_busy_req_dropped", dut_snap(), RST_SNAP);
    check("t6_idle_after_reset", SW'({req_ready_o, busy_o}), SW'(2'b10));
    check("final_queue_empty", SW'(exp_q.size()), SW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
